// File: rtl/serial_twos_collect.sv
// serial_twos_collect: LSB-first serial-to-parallel word collector with a one-deep valid/ready output buffer.
// Optional magnitude/sign outputs are enabled by defining SERIAL_TWOS_COLLECT_MAG_EN.
module serial_twos_collect #(
  parameter int WIDTH = 8
) (
  input  logic             t_clk,
  input  logic             r,
  input  logic             bit_in,
  input  logic             bit_vld,
  input  logic             frame_start,
  input  logic             out_rdy,
  output logic [WIDTH-1:0] word_out,
  output logic             out_vld,
  output logic             ovf,
  output logic             sync_err
`ifdef SERIAL_TWOS_COLLECT_MAG_EN
  ,
  output logic [WIDTH-1:0] mag_out,
  output logic             neg_out
`endif
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sr_q, sr_d, word_q, word_d, full;
  logic             vld_q, vld_d, ovf_q, ovf_d, serr_q, serr_d;
  logic             start, shift, done, load;
  // frame sequencing: capture on frame_start, shift in until bit WIDTH-1, flag restarts mid-word
  always_comb begin
    start   = bit_vld & frame_start;
    shift   = bit_vld & ~frame_start & (state_q == SHIFT);
    done    = shift & (cnt_q == CW'(WIDTH - 1));
    full    = {bit_in, sr_q[WIDTH-1:1]};
    state_d = start ? SHIFT : (done ? IDLE : state_q);
    cnt_d   = start ? CW'(1) : (done ? '0 : (shift ? cnt_q + 1'b1 : cnt_q));
    sr_d    = start ? {bit_in, {(WIDTH-1){1'b0}}} : (shift ? full : sr_q);
    serr_d  = start & (state_q == SHIFT);
  end
  // output buffer: load when empty or being drained, otherwise drop and flag overflow
  always_comb begin
    load   = done & (~vld_q | out_rdy);
    word_d = load ? full : word_q;
    vld_d  = done ? (load | vld_q) : (vld_q & ~out_rdy);
    ovf_d  = ovf_q | (done & ~load);
  end
  // state and output registers
  always_ff @(posedge t_clk or posedge r) begin
    if (r) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      word_q  <= '0;
      vld_q   <= 1'b0;
      ovf_q   <= 1'b0;
      serr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      word_q  <= word_d;
      vld_q   <= vld_d;
      ovf_q   <= ovf_d;
      serr_q  <= serr_d;
    end
  end
  assign word_out = word_q;
  assign out_vld  = vld_q;
  assign ovf      = ovf_q;
  assign sync_err = serr_q;
`ifdef SERIAL_TWOS_COLLECT_MAG_EN
  logic [WIDTH-1:0] msr_q, msr_d, mag_q, mag_d, mfull;
  logic             seen_q, seen_d, neg_q, neg_d, cbit;
  // serial complementer: copy bits through the first 1, invert afterwards; sign is the last bit
  always_comb begin
    cbit   = seen_q ? ~bit_in : bit_in;
    mfull  = {cbit, msr_q[WIDTH-1:1]};
    seen_d = start ? bit_in : (shift ? seen_q | bit_in : seen_q);
    msr_d  = start ? {bit_in, {(WIDTH-1){1'b0}}} : (shift ? mfull : msr_q);
    neg_d  = load ? bit_in : neg_q;
    mag_d  = load ? (bit_in ? mfull : full) : mag_q;
  end
  // magnitude/sign registers
  always_ff @(posedge t_clk or posedge r) begin
    if (r) begin
      msr_q  <= '0;
      seen_q <= 1'b0;
      mag_q  <= '0;
      neg_q  <= 1'b0;
    end else begin
      msr_q  <= msr_d;
      seen_q <= seen_d;
      mag_q  <= mag_d;
      neg_q  <= neg_d;
    end
  end
  assign mag_out = mag_q;
  assign neg_out = neg_q;
`endif
endmodule

// File: tb/tb_serial_twos_collect.sv
// tb_serial_twos_collect: directed table-driven bench for serial_twos_collect.
module tb_serial_twos_collect;
  logic       t_clk = 1'b0;
  logic       r = 1'b1;
  logic       bit_in = 1'b0, bit_vld = 1'b0, frame_start = 1'b0, out_rdy = 1'b1;
  logic [7:0] word_out;
  logic       out_vld, ovf, sync_err;
`ifdef SERIAL_TWOS_COLLECT_MAG_EN
  logic [7:0] mag_out;
  logic       neg_out;
`endif
  int n_chk = 0, n_fail = 0, pulses = 0;
  logic pre_vld;

  serial_twos_collect #(.WIDTH(8)) dut (
    .t_clk(t_clk), .r(r), .bit_in(bit_in), .bit_vld(bit_vld),
    .frame_start(frame_start), .out_rdy(out_rdy), .word_out(word_out),
    .out_vld(out_vld), .ovf(ovf), .sync_err(sync_err)
`ifdef SERIAL_TWOS_COLLECT_MAG_EN
    , .mag_out(mag_out), .neg_out(neg_out)
`endif
  );

  always #5 t_clk = ~t_clk;

  typedef struct {
    logic [7:0] data;
    int         gap;
    logic [7:0] mag;
    logic       neg;
  } vec_t;
  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic send_bit(input logic b, input logic fs);
    bit_in = b;
    frame_start = fs;
    bit_vld = 1'b1;
    @(posedge t_clk);
    #1;
    bit_vld = 1'b0;
    frame_start = 1'b0;
    bit_in = 1'b0;
    if (sync_err) pulses++;
  endtask

  task automatic idle();
    bit_vld = 1'b0;
    bit_in = 1'b1;
    frame_start = 1'b1;
    @(posedge t_clk);
    #1;
    frame_start = 1'b0;
    bit_in = 1'b0;
    if (sync_err) pulses++;
  endtask

  task automatic send_frame(input logic [7:0] data, input int gap);
    for (int i = 0; i < 8; i++) begin
      if (i == 7) pre_vld = out_vld;
      send_bit(data[i], i == 0);
      if (i < 7 && gap != 0) repeat (((i + gap) % 3) + 1) idle();
    end
  endtask

  initial begin
    vecs[0] = '{8'hA5, 0, 8'h5B, 1'b1};
    vecs[1] = '{8'h3C, 1, 8'h3C, 1'b0};
    vecs[2] = '{8'h00, 0, 8'h00, 1'b0};
    vecs[3] = '{8'hFF, 2, 8'h01, 1'b1};
    vecs[4] = '{8'h01, 0, 8'h01, 1'b0};
    vecs[5] = '{8'h80, 3, 8'h80, 1'b1};
    vecs[6] = '{8'hF6, 0, 8'h0A, 1'b1};
    vecs[7] = '{8'h07, 2, 8'h07, 1'b0};

    #12;
    chk("rst_vld", out_vld, 0);
    chk("rst_word", word_out, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_serr", sync_err, 0);
    @(posedge t_clk);
    #1;
    r = 1'b0;

    out_rdy = 1'b1;
    foreach (vecs[k]) begin
      send_frame(vecs[k].data, vecs[k].gap);
      chk("tbl_pre_vld", pre_vld, 0);
      chk("tbl_vld", out_vld, 1);
      chk("tbl_word", word_out, vecs[k].data);
`ifdef SERIAL_TWOS_COLLECT_MAG_EN
      chk("tbl_mag", mag_out, vecs[k].mag);
      chk("tbl_neg", neg_out, vecs[k].neg);
`endif
    end
    chk("tbl_ovf", ovf, 0);
    chk("tbl_no_serr", pulses, 0);
    idle();
    chk("drain_vld", out_vld, 0);
    chk("drain_word_hold", word_out, 8'h07);

    out_rdy = 1'b0;
    send_frame(8'h11, 0);
    chk("bp_vld1", out_vld, 1);
    chk("bp_word1", word_out, 8'h11);
    chk("bp_ovf1", ovf, 0);
    send_frame(8'h22, 0);
    chk("bp_word2", word_out, 8'h11);
    chk("bp_ovf2", ovf, 1);
    chk("bp_vld2", out_vld, 1);
    out_rdy = 1'b1;
    idle();
    chk("bp_drain_vld", out_vld, 0);
    chk("bp_ovf_sticky", ovf, 1);

    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    #2 r = 1'b1;
    #1;
    chk("ar_vld", out_vld, 0);
    chk("ar_word", word_out, 0);
    chk("ar_ovf", ovf, 0);
    @(posedge t_clk);
    #1;
    r = 1'b0;
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    chk("ar_ignored_vld", out_vld, 0);
    send_frame(8'hC3, 0);
    chk("ar_word_next", word_out, 8'hC3);
    chk("ar_vld_next", out_vld, 1);

    pulses = 0;
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    chk("se_none_yet", sync_err, 0);
    send_frame(8'h5A, 0);
    chk("se_count", pulses, 1);
    chk("se_word", word_out, 8'h5A);
    chk("se_vld", out_vld, 1);
    chk("se_clear", sync_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
